// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the filter-processor pipeline control logic:
//   - forwarding select encodings driven to the ALU operand muxes
//   - RUN/STALL state encoding of the interlock FSM
//   - default register-file address width
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_REG_AW = 4;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fwd_sel_lane.sv
// -----------------------------------------------------------------------------
// fwd_sel_lane
// Forwarding select for one source operand of the instruction in EXE.
// Ports:
//   i_exe_rs      source register address of this operand
//   i_exe_re      operand is actually read
//   i_exm_rd/we   destination / write enable in Exe/Mem
//   i_exm_is_load Exe/Mem holds a load (its data is not ready there)
//   i_mwb_rd/we   destination / write enable in Mem/WB
//   o_sel         SEL_REG, SEL_EXM or SEL_MWB
// -----------------------------------------------------------------------------
module fwd_sel_lane
  import pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] i_exe_rs,
  input  logic              i_exe_re,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic              i_exm_we,
  input  logic              i_exm_is_load,
  input  logic [REG_AW-1:0] i_mwb_rd,
  input  logic              i_mwb_we,
  output logic [1:0]        o_sel
);

  logic w_fwd_on;
  logic w_hit_exm;
  logic w_hit_mwb;

  assign w_fwd_on  = (FWD_EN != 0);
  // A load in Exe/Mem has no result yet, so it must not be forwarded from there.
  assign w_hit_exm = w_fwd_on && i_exe_re && i_exm_we && !i_exm_is_load &&
                     (i_exe_rs == i_exm_rd);
  assign w_hit_mwb = w_fwd_on && i_exe_re && i_mwb_we && (i_exe_rs == i_mwb_rd);

  // The younger producer (Exe/Mem) takes priority over Mem/WB.
  always_comb begin
    o_sel = SEL_REG;
    if (w_hit_exm)      o_sel = SEL_EXM;
    else if (w_hit_mwb) o_sel = SEL_MWB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
// Forwarding and load-use interlock controller at the Reg/Exe boundary.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dec_valid/rs/re/rd/we    instruction in the Reg stage (sources, dest)
//   dec_is_load              Reg-stage instruction is a load
//   exe_rs/re                sources of the instruction in EXE
//   exm_rd/we/is_load        Exe/Mem producer
//   mwb_rd/we                Mem/WB producer
//   flush                    kill the Reg-stage instruction
//   sel_fwd                  2-bit forwarding select per EXE source
//   stall, bubble            hold front end / insert NOP (same cycle)
//   stall_cnt                saturating count of cycles spent in STALL
// In-flight loads are tracked by a per-register countdown scoreboard.
// -----------------------------------------------------------------------------
module hazard_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = PIPE_REG_AW,
  parameter int NUM_SRC = 3,
  parameter int MEM_LAT = 2,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]        dec_re,
  input  logic [REG_AW-1:0]         dec_rd,
  input  logic                      dec_we,
  input  logic                      dec_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] exe_rs,
  input  logic [NUM_SRC-1:0]        exe_re,
  input  logic [REG_AW-1:0]         exm_rd,
  input  logic                      exm_we,
  input  logic                      exm_is_load,
  input  logic [REG_AW-1:0]         mwb_rd,
  input  logic                      mwb_we,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      sel_fwd,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int            PW        = $clog2(MEM_LAT + 1);
  localparam int            NREG      = 2 ** REG_AW;
  localparam logic [PW-1:0] PEND_LOAD = PW'(MEM_LAT);

  logic [PW-1:0]    r_pend [NREG];
  fsm_state_t       r_state;
  fsm_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;
  logic [NUM_SRC-1:0] w_src_hit;
  logic             w_hazard;
  logic             w_issue;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
    logic [REG_AW-1:0] w_rs;
    logic              w_wb_dep;

    fwd_sel_lane #(
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
    ) u_lane (
      .i_exe_rs      (exe_rs[gi*REG_AW +: REG_AW]),
      .i_exe_re      (exe_re[gi]),
      .i_exm_rd      (exm_rd),
      .i_exm_we      (exm_we),
      .i_exm_is_load (exm_is_load),
      .i_mwb_rd      (mwb_rd),
      .i_mwb_we      (mwb_we),
      .o_sel         (sel_fwd[2*gi +: 2])
    );

    assign w_rs = dec_rs[gi*REG_AW +: REG_AW];
    // Without forwarding, any producer still in Exe/Mem or Mem/WB blocks the read.
    assign w_wb_dep = (FWD_EN == 0) &&
                      ((exm_we && (w_rs == exm_rd)) || (mwb_we && (w_rs == mwb_rd)));
    assign w_src_hit[gi] = dec_re[gi] && ((r_pend[w_rs] != '0) || w_wb_dep);
  end

  // Reset also masks the hazard so the front end is released in the reset cycle.
  assign w_hazard = dec_valid && !flush && !rst && (|w_src_hit);
  assign stall    = w_hazard;
  assign bubble   = w_hazard;

  // A stalled or flushed load never issues and so never touches the scoreboard.
  assign w_issue = dec_valid && dec_we && dec_is_load && !w_hazard && !flush;

  // Scoreboard countdown: reload on issue wins over the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_issue && (dec_rd == REG_AW'(r))) r_pend[r] <= PEND_LOAD;
        else if (r_pend[r] != '0)              r_pend[r] <= r_pend[r] - PW'(1);
      end
    end
  end

  // Interlock FSM: registered copy of the hazard, flush forces RUN.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    w_cnt_inc   = 1'b0;
    if (!flush && w_hazard) w_state_nxt = ST_STALL;
    if ((r_state == ST_STALL) && (r_cnt != '1)) w_cnt_inc = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_cnt;

endmodule
